// File: rtl/uart_to_hex_pkg.sv
// Shared PDU receive-side definitions: FSM state encoding, ASCII constants
// and the character-to-nibble helper used by the decoder.
package uart_to_hex_pkg;

  // Parser states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  // Terminator characters
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  // Digit range bounds
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UF = 8'h46;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LF_CHAR = 8'h66;

  // Returns {is_digit, nibble}; nibble is 0 when the character is not a digit.
  function automatic logic [4:0] ascii_hex_value(input logic [7:0] c);
    logic [7:0] d;
    logic [4:0] r;
    r = 5'd0;
    d = 8'd0;
    if (c >= ASCII_0 && c <= ASCII_9) begin
      d = c - ASCII_0;
      r = {1'b1, d[3:0]};
    end else if (c >= ASCII_UA && c <= ASCII_UF) begin
      d = c - ASCII_UA + 8'd10;
      r = {1'b1, d[3:0]};
    end else if (c >= ASCII_LA && c <= ASCII_LF_CHAR) begin
      d = c - ASCII_LA + 8'd10;
      r = {1'b1, d[3:0]};
    end
    return r;
  endfunction

  // True for the characters that close a word.
  function automatic logic ascii_is_term(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF) || (c == ASCII_SP);
  endfunction

endpackage

// File: rtl/uart_to_hex_decode.sv
// Combinational character classifier: splits an ASCII byte into
// digit / terminator flags and the hex nibble value.
module hex_ascii_decode
  import uart_to_hex_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_is_digit,
  output logic       o_is_term,
  output logic [3:0] o_nibble
);

  logic [4:0] w_hex;

  // Classify the character; digits and terminators are mutually exclusive.
  always_comb begin
    w_hex      = ascii_hex_value(i_char);
    o_is_digit = w_hex[4];
    o_nibble   = w_hex[3:0];
    o_is_term  = ascii_is_term(i_char);
  end

endmodule

// File: rtl/uart_to_hex.sv
// UART RX character stream to 32-bit hex word parser. Accumulates up to
// MAX_DIGITS hex digits, closes the word on CR/LF/SP and holds it until the
// consumer accepts it. All outputs are registered.
module uart_to_hex
  import uart_to_hex_pkg::*;
#(
  parameter int HEX_WIDTH  = 32,
  parameter int MAX_DIGITS = HEX_WIDTH / 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_data_valid,
  output logic [HEX_WIDTH-1:0] hex_data,
  output logic                 hex_data_valid,
  input  logic                 hex_data_accept,
  output logic                 parse_error,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic                 w_is_digit;
  logic                 w_is_term;
  logic [3:0]           w_nibble;

  state_t               r_state;
  state_t               w_state_next;
  logic [HEX_WIDTH-1:0] r_acc;
  logic [HEX_WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_next;
  logic [HEX_WIDTH-1:0] r_hex_data;
  logic [HEX_WIDTH-1:0] w_hex_data_next;
  logic                 r_hex_valid;
  logic                 w_hex_valid_next;
  logic                 r_parse_error;
  logic                 w_parse_error_next;
  logic                 r_overrun;
  logic                 w_overrun_next;

  hex_ascii_decode u_decode (
    .i_char     (rx_data),
    .o_is_digit (w_is_digit),
    .o_is_term  (w_is_term),
    .o_nibble   (w_nibble)
  );

  // State, accumulator, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_acc         <= '0;
      r_count       <= '0;
      r_hex_data    <= '0;
      r_hex_valid   <= 1'b0;
      r_parse_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_acc         <= w_acc_next;
      r_count       <= w_count_next;
      r_hex_data    <= w_hex_data_next;
      r_hex_valid   <= w_hex_valid_next;
      r_parse_error <= w_parse_error_next;
      r_overrun     <= w_overrun_next;
    end
  end

  // Next-state and next-output logic; characters are acted on only when strobed,
  // except the accept check in HOLD.
  always_comb begin
    w_state_next       = r_state;
    w_acc_next         = r_acc;
    w_count_next       = r_count;
    w_hex_data_next    = r_hex_data;
    w_hex_valid_next   = r_hex_valid;
    w_parse_error_next = 1'b0;
    w_overrun_next     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (rx_data_valid) begin
          if (w_is_digit) begin
            w_acc_next   = {r_acc[HEX_WIDTH-5:0], w_nibble};
            w_count_next = CNT_W'(1);
            w_state_next = ST_COLLECT;
          end else if (!w_is_term) begin
            // Terminators on an empty word are silently ignored.
            w_parse_error_next = 1'b1;
            w_state_next       = ST_DISCARD;
          end
        end
      end

      ST_COLLECT: begin
        if (rx_data_valid) begin
          if (w_is_digit) begin
            if (r_count < CNT_W'(MAX_DIGITS)) begin
              w_acc_next   = {r_acc[HEX_WIDTH-5:0], w_nibble};
              w_count_next = r_count + CNT_W'(1);
            end else begin
              // One digit too many: the whole word is abandoned.
              w_parse_error_next = 1'b1;
              w_state_next       = ST_DISCARD;
            end
          end else if (w_is_term) begin
            // Short words come out zero-extended because acc started from zero.
            w_hex_data_next  = r_acc;
            w_hex_valid_next = 1'b1;
            w_state_next     = ST_HOLD;
          end else begin
            w_parse_error_next = 1'b1;
            w_state_next       = ST_DISCARD;
          end
        end
      end

      ST_HOLD: begin
        // The held word is never disturbed by incoming characters.
        if (rx_data_valid) begin
          w_overrun_next = 1'b1;
        end
        if (hex_data_accept) begin
          w_hex_data_next  = '0;
          w_hex_valid_next = 1'b0;
          w_acc_next       = '0;
          w_count_next     = '0;
          w_state_next     = ST_IDLE;
        end
      end

      ST_DISCARD: begin
        if (rx_data_valid && w_is_term) begin
          w_acc_next   = '0;
          w_count_next = '0;
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign hex_data       = r_hex_data;
  assign hex_data_valid = r_hex_valid;
  assign parse_error    = r_parse_error;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_uart_to_hex.sv
// Self-checking bench for uart_to_hex: scoreboard of expected words, pulse
// counters for parse_error/overrun, one task per scenario.
module tb_uart_to_hex;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic [31:0] hex_data;
  logic        hex_data_valid;
  logic        hex_data_accept;
  logic        parse_error;
  logic        overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int perr_cnt = 0;
  int ovr_cnt  = 0;
  logic [31:0] exp_q[$];

  uart_to_hex #(.HEX_WIDTH(32), .MAX_DIGITS(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_data_valid   (rx_data_valid),
    .hex_data        (hex_data),
    .hex_data_valid  (hex_data_valid),
    .hex_data_accept (hex_data_accept),
    .parse_error     (parse_error),
    .overrun         (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (parse_error) perr_cnt++;
    if (overrun) ovr_cnt++;
  end

  // Caller is positioned 1 time unit after a rising edge.
  task automatic send_char(input logic [7:0] c);
    rx_data       = c;
    rx_data_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_data_valid = 1'b0;
    rx_data       = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept_word();
    hex_data_accept = 1'b1;
    @(posedge clk);
    #1;
    hex_data_accept = 1'b0;
  endtask

  // Bounded wait for hex_data_valid; reports the word seen and whether the bound expired.
  task automatic wait_valid(output logic [31:0] w, output bit timed_out);
    int k;
    k = 0;
    timed_out = 1'b0;
    while (!hex_data_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!hex_data_valid) timed_out = 1'b1;
    w = hex_data;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx_data = 8'h00;
    rx_data_valid = 1'b0;
    hex_data_accept = 1'b0;
    idle_cycles(3);
    n_checks++;
    if ({hex_data, hex_data_valid, parse_error, overrun} !== 35'd0)
      $display("FAIL reset_outputs: got data=%h v=%b pe=%b ov=%b, want all 0",
               hex_data, hex_data_valid, parse_error, overrun);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_deadbeef();
    logic [31:0] w;
    logic [31:0] e;
    bit to;
    exp_q.push_back(32'hDEADBEEF);
    send_str("DEADBEEF");
    n_checks++;
    if (hex_data_valid !== 1'b0)
      $display("FAIL deadbeef_early_valid: got %b, want 0", hex_data_valid);
    else n_pass++;
    send_char(8'h0A);
    // Terminator sampled at edge t; valid must already be up in cycle t+1.
    n_checks++;
    if (hex_data_valid !== 1'b1)
      $display("FAIL deadbeef_latency: valid=%b one cycle after LF, want 1", hex_data_valid);
    else n_pass++;
    wait_valid(w, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || w !== e) $display("FAIL deadbeef_word: got %h (timeout=%0b), want %h", w, to, e);
    else n_pass++;
    accept_word();
    n_checks++;
    if (hex_data_valid !== 1'b0 || hex_data !== 32'd0)
      $display("FAIL deadbeef_accept: valid=%b data=%h, want 0/0", hex_data_valid, hex_data);
    else n_pass++;
    $display("deadbeef: word %h", w);
  endtask

  task automatic test_lowercase_and_empty();
    logic [31:0] w;
    logic [31:0] e;
    bit to;
    int p0;
    exp_q.push_back(32'h0000001F);
    send_str("1f ");
    wait_valid(w, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || w !== e) $display("FAIL lower_word: got %h (timeout=%0b), want %h", w, to, e);
    else n_pass++;
    accept_word();
    p0 = perr_cnt;
    send_str("\r\n");
    idle_cycles(3);
    n_checks++;
    if (hex_data_valid !== 1'b0 || perr_cnt != p0)
      $display("FAIL empty_word: valid=%b errors=%0d, want 0/0", hex_data_valid, perr_cnt - p0);
    else n_pass++;
    $display("lowercase: word %h, empty line ignored", w);
  endtask

  task automatic test_bad_char();
    logic [31:0] w;
    logic [31:0] e;
    bit to;
    int p0;
    p0 = perr_cnt;
    send_str("12G");
    n_checks++;
    if (parse_error !== 1'b1) $display("FAIL badchar_pulse: parse_error=%b after G, want 1", parse_error);
    else n_pass++;
    send_str("4\n");
    idle_cycles(2);
    n_checks++;
    if (perr_cnt - p0 != 1 || hex_data_valid !== 1'b0)
      $display("FAIL badchar_discard: errors=%0d valid=%b, want 1/0", perr_cnt - p0, hex_data_valid);
    else n_pass++;
    exp_q.push_back(32'h000000AB);
    send_str("AB\n");
    wait_valid(w, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || w !== e) $display("FAIL badchar_recover: got %h (timeout=%0b), want %h", w, to, e);
    else n_pass++;
    accept_word();
    $display("bad_char: recovered word %h", w);
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    logic [31:0] e;
    bit to;
    int p0;
    p0 = perr_cnt;
    send_str("12345678");
    n_checks++;
    if (perr_cnt != p0) $display("FAIL overflow_8digits: errors=%0d after 8 digits, want 0", perr_cnt - p0);
    else n_pass++;
    send_str("9\n");
    idle_cycles(2);
    n_checks++;
    if (perr_cnt - p0 != 1 || hex_data_valid !== 1'b0)
      $display("FAIL overflow_9th: errors=%0d valid=%b, want 1/0", perr_cnt - p0, hex_data_valid);
    else n_pass++;
    exp_q.push_back(32'h00000007);
    send_str("7\n");
    wait_valid(w, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || w !== e) $display("FAIL overflow_recover: got %h (timeout=%0b), want %h", w, to, e);
    else n_pass++;
    accept_word();
    $display("overflow: recovered word %h", w);
  endtask

  task automatic test_back_to_back_overrun();
    logic [31:0] w;
    logic [31:0] e;
    bit to;
    int o0;
    exp_q.push_back(32'h00000055);
    send_str("55\n");
    o0 = ovr_cnt;
    send_str("66\n");
    idle_cycles(2);
    n_checks++;
    if (ovr_cnt - o0 != 3) $display("FAIL overrun_count: got %0d pulses, want 3", ovr_cnt - o0);
    else n_pass++;
    wait_valid(w, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || w !== e) $display("FAIL overrun_hold: got %h (timeout=%0b), want %h", w, to, e);
    else n_pass++;
    accept_word();
    n_checks++;
    if (hex_data_valid !== 1'b0) $display("FAIL overrun_accept: valid=%b, want 0", hex_data_valid);
    else n_pass++;
    exp_q.push_back(32'h00000077);
    send_str("77\n");
    wait_valid(w, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || w !== e) $display("FAIL overrun_next: got %h (timeout=%0b), want %h", w, to, e);
    else n_pass++;
    accept_word();
    $display("overrun: next word %h", w);
  endtask

  task automatic test_reset_midword();
    logic [31:0] w;
    logic [31:0] e;
    bit to;
    send_str("ABC");
    rst = 1'b0;
    #1;
    n_checks++;
    if ({hex_data, hex_data_valid, parse_error, overrun} !== 35'd0)
      $display("FAIL reset_midword: data=%h v=%b, want 0", hex_data, hex_data_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_str("5\n");
    n_checks++;
    if (hex_data_valid !== 1'b1 || hex_data !== 32'h5)
      $display("FAIL reset_prehold: data=%h v=%b, want 00000005/1", hex_data, hex_data_valid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (hex_data !== 32'd0 || hex_data_valid !== 1'b0)
      $display("FAIL reset_hold: data=%h v=%b, want 0/0", hex_data, hex_data_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(32'h00000009);
    send_str("9\n");
    wait_valid(w, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || w !== e) $display("FAIL reset_recover: got %h (timeout=%0b), want %h", w, to, e);
    else n_pass++;
    accept_word();
    $display("reset: recovered word %h", w);
  endtask

  initial begin
    test_reset();
    test_deadbeef();
    test_lowercase_and_empty();
    test_bad_char();
    test_overflow();
    test_back_to_back_overrun();
    test_reset_midword();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d words left, want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
